// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extraction/extension stage with a
// valid/ready handshake on both sides and a two-entry (main + skid) buffer.
//
// Parameters:
//   XLEN   - immediate output width (32 or 64)
//   TAG_W  - sideband tag width (PC or instruction ID)
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   in_valid / in_ready    - input handshake (in_ready is registered)
//   instr, imm_src, in_tag - instruction word, format select, sideband tag
//   out_valid / out_ready  - output handshake
//   imm_ext, out_tag       - extended immediate and its paired tag
//   out_illegal            - reserved-format flag (only with IMM_EXTEND_ILLEGAL_EN)
//
// Optional feature macro: IMM_EXTEND_ILLEGAL_EN
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
`ifdef IMM_EXTEND_ILLEGAL_EN
  output logic             out_illegal,
`endif
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
`ifdef IMM_EXTEND_ILLEGAL_EN
    logic             illegal;
`endif
  } entry_t;

  logic [31:0] imm32_c;
  entry_t      new_c;
  entry_t      main_q, main_n;
  entry_t      skid_q, skid_n;
  logic        main_valid_q, main_valid_n;
  logic        skid_valid_q, skid_valid_n;
  logic        in_ready_q;
  logic        in_fire_c, out_fire_c;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Format decode to a 32-bit immediate; bit 31 always carries the sign.
  always_comb begin
    imm32_c = '0;
    case (imm_src)
      3'b000:  imm32_c = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      3'b011:  imm32_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      3'b100:  imm32_c = {instr[31:12], 12'b0};
      3'b101:  imm32_c = {27'b0, instr[19:15]};
      default: imm32_c = '0;
    endcase
  end

  // Widen to XLEN by replicating bit 31 (zero for Z and reserved codes).
  always_comb begin
    new_c     = '0;
    new_c.imm = XLEN'($signed(imm32_c));
    new_c.tag = in_tag;
`ifdef IMM_EXTEND_ILLEGAL_EN
    new_c.illegal = imm_src[2] & imm_src[1];
`endif
  end

  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = main_valid_q & out_ready;

  // Buffer next-state; in_ready is low whenever skid holds data, so an
  // input transfer never coincides with a full skid.
  always_comb begin
    main_n       = main_q;
    skid_n       = skid_q;
    main_valid_n = main_valid_q;
    skid_valid_n = skid_valid_q;
    if (skid_valid_q) begin
      if (out_fire_c) begin
        main_n       = skid_q;
        skid_valid_n = 1'b0;
      end
    end else if (in_fire_c) begin
      if (!main_valid_q || out_fire_c) begin
        main_n       = new_c;
        main_valid_n = 1'b1;
      end else begin
        skid_n       = new_c;
        skid_valid_n = 1'b1;
      end
    end else if (out_fire_c) begin
      main_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_n;
      skid_q       <= skid_n;
      main_valid_q <= main_valid_n;
      skid_valid_q <= skid_valid_n;
      in_ready_q   <= ~skid_valid_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign imm_ext   = main_q.imm;
  assign out_tag   = main_q.tag;
`ifdef IMM_EXTEND_ILLEGAL_EN
  assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: an XLEN=64 and an XLEN=32
// instance share stimulus; a scoreboard queue holds expected outputs.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [31:0] tag32;
`ifdef IMM_EXTEND_ILLEGAL_EN
  logic        ill64, ill32;
`endif

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .imm_ext(imm64),
`ifdef IMM_EXTEND_ILLEGAL_EN
    .out_illegal(ill64),
`endif
    .out_tag(tag64));

  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm32),
`ifdef IMM_EXTEND_ILLEGAL_EN
    .out_illegal(ill32),
`endif
    .out_tag(tag32));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  vec_t  vecs[12];
  exp_t  sb[$];
  exp_t  next_exp;
  int    tests = 0;
  int    fails = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_imm;
  logic [31:0] prev_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode built directly at 64 bits.
  function automatic exp_t model(input logic [31:0] w, input logic [2:0] s, input logic [31:0] t);
    exp_t e;
    logic sg;
    sg = w[31];
    e.imm = '0;
    case (s)
      3'd0: e.imm = {{52{sg}}, w[31:20]};
      3'd1: e.imm = {{52{sg}}, w[31:25], w[11:7]};
      3'd2: e.imm = {{52{sg}}, w[7], w[30:25], w[11:8], 1'b0};
      3'd3: e.imm = {{44{sg}}, w[19:12], w[20], w[30:21], 1'b0};
      3'd4: e.imm = {{32{sg}}, w[31:12], 12'b0};
      3'd5: e.imm = {59'b0, w[19:15]};
      default: e.imm = '0;
    endcase
    e.tag = t;
    e.ill = s[2] & s[1];
    return e;
  endfunction

  // One clock cycle: entered just after a falling edge with inputs set;
  // samples handshakes 1 time unit before the rising edge.
  task automatic step();
    exp_t e;
    #4;
    if (prev_stall) begin
      check("stall_stable_imm", imm64, prev_imm);
      check("stall_stable_tag", {32'b0, tag64}, {32'b0, prev_tag});
    end
    prev_stall = out_valid && !out_ready;
    prev_imm   = imm64;
    prev_tag   = tag64;
    if (in_valid && in_ready) sb.push_back(next_exp);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(tag64), 64'hDEAD_0000);
      end else begin
        e = sb.pop_front();
        check("imm64", imm64, e.imm);
        check("tag64", {32'b0, tag64}, {32'b0, e.tag});
        check("imm32", {32'b0, imm32}, {32'b0, e.imm[31:0]});
        check("tag32", {32'b0, tag32}, {32'b0, e.tag});
        check("valid32", {63'b0, out_valid32}, 64'd1);
`ifdef IMM_EXTEND_ILLEGAL_EN
        check("illegal64", {63'b0, ill64}, {63'b0, e.ill});
        check("illegal32", {63'b0, ill32}, {63'b0, e.ill});
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int tag;
    int accepted;
    logic fire;

    vecs[0]  = '{32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{32'h80000063, 3'd2, 64'hFFFF_FFFF_FFFF_F000, 1'b0};
    vecs[2]  = '{32'h123450B7, 3'd4, 64'h0000_0000_1234_5000, 1'b0};
    vecs[3]  = '{32'h000F8000, 3'd5, 64'h0000_0000_0000_001F, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 3'd7, 64'h0000_0000_0000_0000, 1'b1};
    vecs[5]  = '{32'h12345678, 3'd6, 64'h0000_0000_0000_0000, 1'b1};
    vecs[6]  = '{32'h02000100, 3'd1, 64'h0000_0000_0000_0022, 1'b0};
    vecs[7]  = '{32'h8000006F, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 1'b0};
    vecs[8]  = '{32'h00301000, 3'd3, 64'h0000_0000_0000_1802, 1'b0};
    vecs[9]  = '{32'h02000180, 3'd2, 64'h0000_0000_0000_0822, 1'b0};
    vecs[10] = '{32'h7FF00013, 3'd0, 64'h0000_0000_0000_07FF, 1'b0};
    vecs[11] = '{32'h80000037, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0};

    reset = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0; in_tag = '0; out_ready = 1'b0;
    next_exp = '{64'd0, 32'd0, 1'b0};
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'b0, in_ready}, 64'd0);
    check("rst_imm",       imm64, 64'd0);
    check("rst_tag",       {32'b0, tag64}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 check("in_ready_before_edge", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("in_ready_after_release", {63'b0, in_ready}, 64'd1);
    @(negedge clk);

    // Table stream at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      imm_src  = vecs[i].src;
      in_tag   = 32'h100 + 32'(i);
      next_exp = '{vecs[i].imm, 32'h100 + 32'(i), vecs[i].ill};
      check("tput_in_ready", {63'b0, in_ready}, 64'd1);
      if (i > 0) check("tput_out_valid", {63'b0, out_valid}, 64'd1);
      step();
    end
    in_valid = 1'b0;
    step();
    check("tput_drained", 64'(sb.size()), 64'd0);

    // Backpressure: out_ready low for 3 cycles while tags 1..4 are offered.
    tag = 1; accepted = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (tag <= 4);
      instr     = 32'h00100093 + (32'(tag) << 20);
      imm_src   = 3'd0;
      in_tag    = 32'(tag);
      next_exp  = model(instr, imm_src, in_tag);
      if (cyc == 2) begin
        check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        check("bp_accepted", 64'(accepted), 64'd2);
      end
      fire = in_valid && in_ready;
      step();
      if (fire) begin tag++; accepted++; end
    end
    check("bp_all_accepted", 64'(accepted), 64'd4);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Reset while both entries hold data.
    out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd4;
    for (int i = 0; i < 2; i++) begin
      instr = 32'hABCDE000 + 32'(i); in_tag = 32'h5A0 + 32'(i);
      next_exp = model(instr, imm_src, in_tag);
      step();
    end
    in_valid = 1'b0;
    check("full_in_ready_low", {63'b0, in_ready}, 64'd0);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'b0, in_ready}, 64'd0);
    check("midrst_imm",       imm64, 64'd0);
    check("midrst_tag",       {32'b0, tag64}, 64'd0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_output", {63'b0, out_valid}, 64'd0);
    end

    // Random valid/ready traffic over all formats.
    tag = 1000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = 32'(tag);
      next_exp  = model(instr, imm_src, in_tag);
      fire = in_valid && in_ready;
      step();
      if (fire) tag++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    check("random_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
